// File: rtl/crc_gen_16bit_tx.sv
// USB Tx data-packet serializer: payload bytes out LSB first, then the complemented CRC16.
// Optional macro USB_TX_STUFF_HOLD_EN adds a stuff_hold input that masks bit_strobe.
module crc_gen_16bit_tx #(
    parameter logic [15:0] CRC_INIT  = 16'hFFFF,
    parameter int          MAX_BYTES = 1023
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       bit_strobe,
    output logic       tx_bit,
    output logic       tx_bit_valid,
    output logic       tx_crc_phase,
    output logic       tx_done,
    output logic       busy,
    output logic [9:0] byte_count,
    output logic       err_len,
`ifdef USB_TX_STUFF_HOLD_EN
    input  logic       stuff_hold,
`endif
    input  logic       abort
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DATA, S_CRC, S_DONE} state_t;

    localparam logic [9:0] MAX_CNT = 10'(MAX_BYTES);

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        last_q, last_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [3:0]  crc_idx_q, crc_idx_d;
    logic [9:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        adv, accept, zero_len, fb;

`ifdef USB_TX_STUFF_HOLD_EN
    // The stuffer inserting a stuff bit freezes the stream for that strobe.
    assign adv = bit_strobe & ~stuff_hold;
`else
    assign adv = bit_strobe;
`endif

    assign accept   = byte_valid & byte_ready;
    assign zero_len = ~byte_valid & byte_last & (count_q == 10'd0);
    assign fb       = shreg_q[0] ^ crc_q[15];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            crc_q     <= CRC_INIT;
            shreg_q   <= 8'd0;
            last_q    <= 1'b0;
            bit_idx_q <= 3'd0;
            crc_idx_q <= 4'd0;
            count_q   <= 10'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            bit_idx_q <= bit_idx_d;
            crc_idx_q <= crc_idx_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (tx_start) state_d = S_FETCH;
                S_FETCH: begin
                    if (accept)        state_d = S_DATA;
                    else if (zero_len) state_d = S_CRC;
                end
                S_DATA:  if (adv && bit_idx_q == 3'd7) state_d = last_q ? S_CRC : S_FETCH;
                S_CRC:   if (adv && crc_idx_q == 4'd0) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        crc_d     = crc_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        bit_idx_d = bit_idx_q;
        crc_idx_d = crc_idx_q;
        count_d   = count_q;
        err_d     = err_q;
        if (!abort) begin
            case (state_q)
                S_IDLE: if (tx_start) begin
                    crc_d   = CRC_INIT;
                    count_d = 10'd0;
                    err_d   = 1'b0;
                end
                S_FETCH: begin
                    if (accept) begin
                        shreg_d   = byte_data;
                        last_d    = byte_last;
                        count_d   = count_q + 10'd1;
                        bit_idx_d = 3'd0;
                    end else if (zero_len) begin
                        crc_idx_d = 4'd15;
                    end
                    // Overlong packet: flag it and leave the byte unconsumed until abort.
                    if (byte_valid && count_q == MAX_CNT) err_d = 1'b1;
                end
                S_DATA: if (adv) begin
                    crc_d     = {crc_q[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    crc_idx_d = 4'd15;
                end
                S_CRC: if (adv) crc_idx_d = crc_idx_q - 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_ready   = 1'b0;
        tx_bit       = 1'b1;
        tx_bit_valid = 1'b0;
        tx_crc_phase = 1'b0;
        tx_done      = 1'b0;
        case (state_q)
            S_FETCH: byte_ready = (count_q != MAX_CNT);
            S_DATA: begin
                tx_bit       = shreg_q[0];
                tx_bit_valid = 1'b1;
            end
            S_CRC: begin
                tx_bit       = ~crc_q[crc_idx_q];
                tx_bit_valid = 1'b1;
                tx_crc_phase = 1'b1;
            end
            S_DONE:  tx_done = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign byte_count = count_q;
    assign err_len    = err_q;

endmodule
